// File: rtl/seq_det_pkg.sv
// Shared types and reset defaults for the seq_det_ctrl pattern-detection controller.
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [15:0] DEF_PATTERN = 16'h000D;
  localparam int          DEF_LEN     = 4;
  localparam logic        DEF_OVERLAP = 1'b1;
  localparam int          DEF_TARGET  = 0;

endpackage

// File: rtl/seq_det_matcher.sv
// History shift register, fill counter and length-masked pattern compare.
// hit is combinational on the incoming bit; the caller qualifies it with state and in_valid.
module seq_det_matcher
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               shift,
  input  logic               clear,
  input  logic               din,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               hit
);

  logic [MAX_LEN-2:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic [MAX_LEN-1:0] w_window;
  logic [MAX_LEN-1:0] w_mask;

  assign w_window = {r_hist, din};
  // A shift by len == MAX_LEN empties the inverted field, giving an all-ones mask.
  assign w_mask   = ~({MAX_LEN{1'b1}} << len);
  assign hit      = (r_fill >= (len - LEN_W'(1'b1))) &&
                    ((w_window & w_mask) == (pattern & w_mask));

  // History and fill count; clear takes priority over a shift on the same edge.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_hist <= {(MAX_LEN-1){1'b0}};
      r_fill <= {LEN_W{1'b0}};
    end else if (shift) begin
      r_hist <= w_window[MAX_LEN-2:0];
      if (r_fill < len) begin
        r_fill <= r_fill + LEN_W'(1'b1);
      end else begin
        r_fill <= r_fill;
      end
    end else begin
      r_hist <= r_hist;
      r_fill <= r_fill;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Programmable serial pattern-detection controller (IDLE/RUN/DONE) with match counter.
// Optional first-match index capture is enabled by defining SEQ_DET_FIRST_MATCH_IDX_EN.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  output logic               cfg_err,
  input  logic               start,
  input  logic               stop,
  input  logic               in_valid,
  input  logic               in,
  output logic               out,
  output logic               busy,
  output logic               done,
`ifdef SEQ_DET_FIRST_MATCH_IDX_EN
  output logic               first_vld,
  output logic [15:0]        first_idx,
`endif
  output logic [CNT_W-1:0]   match_cnt
);

  state_t             r_state;
  state_t             w_next;
  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic [CNT_W-1:0]   r_target;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_cfg_err;

  logic               w_cfg_hs;
  logic               w_cfg_legal;
  logic               w_start_go;
  logic               w_run;
  logic               w_shift;
  logic               w_hit;
  logic               w_out;
  logic               w_clear;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_hit_target;

  assign w_cfg_hs     = cfg_valid && cfg_ready;
  assign w_cfg_legal  = (cfg_len >= LEN_W'(2)) && (cfg_len <= LEN_W'(MAX_LEN));
  // A pending config always beats start in the same cycle.
  assign w_start_go   = start && cfg_ready && !cfg_valid;
  assign w_run        = (r_state == ST_RUN);
  assign w_shift      = w_run && in_valid;
  assign w_out        = w_shift && w_hit;
  assign w_clear      = w_start_go || (w_out && !r_overlap);
  assign w_cnt_inc    = (&r_cnt) ? r_cnt : (r_cnt + CNT_W'(1'b1));
  assign w_hit_target = w_out && (r_target != {CNT_W{1'b0}}) && (w_cnt_inc == r_target);

  assign out       = w_out;
  assign cfg_err   = r_cfg_err;
  assign match_cnt = r_cnt;

  seq_det_matcher #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_matcher (
    .clk     (clk),
    .rst     (rst),
    .shift   (w_shift),
    .clear   (w_clear),
    .din     (in),
    .pattern (r_pattern),
    .len     (r_len),
    .hit     (w_hit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; reaching the target wins over a simultaneous stop.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_start_go) w_next = ST_RUN;
        else            w_next = r_state;
      end
      ST_RUN: begin
        if (w_hit_target) w_next = ST_DONE;
        else if (stop)    w_next = ST_IDLE;
        else              w_next = ST_RUN;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    cfg_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (r_state)
      ST_IDLE: cfg_ready = 1'b1;
      ST_RUN:  busy      = 1'b1;
      ST_DONE: begin
        cfg_ready = 1'b1;
        done      = 1'b1;
      end
      default: begin
        cfg_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
      end
    endcase
  end

  // Config registers and the one-cycle illegal-length error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pattern <= DEF_PATTERN[MAX_LEN-1:0];
      r_len     <= LEN_W'(DEF_LEN);
      r_overlap <= DEF_OVERLAP;
      r_target  <= CNT_W'(DEF_TARGET);
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_cfg_hs && !w_cfg_legal;
      if (w_cfg_hs && w_cfg_legal) begin
        r_pattern <= cfg_pattern;
        r_len     <= cfg_len;
        r_overlap <= cfg_overlap;
        r_target  <= cfg_target;
      end else begin
        r_pattern <= r_pattern;
        r_len     <= r_len;
        r_overlap <= r_overlap;
        r_target  <= r_target;
      end
    end
  end

  // Saturating match counter, cleared when a run starts.
  always_ff @(posedge clk) begin
    if (rst || w_start_go) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_out) begin
      r_cnt <= w_cnt_inc;
    end else begin
      r_cnt <= r_cnt;
    end
  end

`ifdef SEQ_DET_FIRST_MATCH_IDX_EN
  logic [15:0] r_bit_idx;
  logic [15:0] r_first_idx;
  logic        r_first_vld;

  assign first_vld = r_first_vld;
  assign first_idx = r_first_idx;

  // Index of valid bits within the run and capture of the first matching one.
  always_ff @(posedge clk) begin
    if (rst || w_start_go) begin
      r_bit_idx   <= 16'h0000;
      r_first_idx <= 16'h0000;
      r_first_vld <= 1'b0;
    end else begin
      if (w_out && !r_first_vld) begin
        r_first_vld <= 1'b1;
        r_first_idx <= r_bit_idx;
      end else begin
        r_first_vld <= r_first_vld;
        r_first_idx <= r_first_idx;
      end
      if (w_shift && (r_bit_idx != 16'hFFFF)) begin
        r_bit_idx <= r_bit_idx + 16'h0001;
      end else begin
        r_bit_idx <= r_bit_idx;
      end
    end
  end
`endif

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Scoreboard bench for seq_det_ctrl: a bit-queue reference model predicts each cycle's outputs.
module tb_seq_det_ctrl;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;
  localparam int LEN_W   = $clog2(MAX_LEN) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, cfg_valid, cfg_overlap, start, stop, in_valid, din;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic [CNT_W-1:0]   cfg_target;
  logic               cfg_ready, cfg_err, dout, busy, done;
  logic [CNT_W-1:0]   match_cnt;
`ifdef SEQ_DET_FIRST_MATCH_IDX_EN
  logic               first_vld;
  logic [15:0]        first_idx;
`endif

  seq_det_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_target(cfg_target), .cfg_err(cfg_err), .start(start), .stop(stop),
    .in_valid(in_valid), .in(din), .out(dout), .busy(busy), .done(done),
`ifdef SEQ_DET_FIRST_MATCH_IDX_EN
    .first_vld(first_vld), .first_idx(first_idx),
`endif
    .match_cnt(match_cnt)
  );

  typedef struct {
    bit out, busy, done, ready, err, fvld;
    int cnt, fidx;
    int d_cnt, d_busy, d_done, d_out, d_err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  // Reference model state: 0 = idle, 1 = running, 2 = finished.
  int m_state, m_pat, m_len, m_tgt, m_cnt, m_bidx, m_fidx;
  bit m_ov, m_err, m_fvld;
  bit m_hist[$];

  int dir_cnt = -1, dir_busy = -1, dir_done = -1, dir_out = -1, dir_err = -1;
  int total = 0, bad = 0;
  bit fin_req = 1'b0;

  function automatic void model_reset();
    m_state = 0; m_pat = 13; m_len = 4; m_ov = 1'b1; m_tgt = 0; m_cnt = 0;
    m_err = 1'b0; m_hist.delete(); m_bidx = 0; m_fvld = 1'b0; m_fidx = 0;
  endfunction

  // Value of the last len valid bits (oldest first) including b, against the pattern.
  function automatic bit model_match(bit b);
    int v;
    if (m_hist.size() + 1 < m_len) return 1'b0;
    v = 0;
    for (int i = m_len - 1; i >= 1; i--) v = (v << 1) | int'(m_hist[m_hist.size() - i]);
    v = (v << 1) | int'(b);
    return v == (m_pat % (1 << m_len));
  endfunction

  task automatic step();
    exp_t e;
    bit   hit, ready;
    int   l;
    ready   = (m_state != 1);
    hit     = (m_state == 1) && in_valid && model_match(din);
    e.out   = hit;          e.busy = (m_state == 1); e.done = (m_state == 2);
    e.ready = ready;        e.err  = m_err;          e.cnt  = m_cnt;
    e.fvld  = m_fvld;       e.fidx = m_fidx;
    e.d_cnt = dir_cnt;      e.d_busy = dir_busy;     e.d_done = dir_done;
    e.d_out = dir_out;      e.d_err  = dir_err;
    dir_cnt = -1; dir_busy = -1; dir_done = -1; dir_out = -1; dir_err = -1;
    sb_q.push_back(e);
    if (rst) begin
      model_reset();
    end else begin
      l     = int'(cfg_len);
      m_err = ready && cfg_valid && (l < 2 || l > MAX_LEN);
      if (ready) begin
        if (cfg_valid) begin
          if (l >= 2 && l <= MAX_LEN) begin
            m_pat = int'(cfg_pattern); m_len = l; m_ov = cfg_overlap; m_tgt = int'(cfg_target);
          end
        end else if (start) begin
          m_state = 1; m_hist.delete(); m_cnt = 0; m_bidx = 0; m_fvld = 1'b0; m_fidx = 0;
        end
      end else begin
        if (in_valid) begin
          if (hit) begin
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
            if (!m_fvld) begin m_fvld = 1'b1; m_fidx = m_bidx; end
          end
          if (hit && !m_ov) m_hist.delete();
          else begin
            m_hist.push_back(din);
            if (m_hist.size() > 16) void'(m_hist.pop_front());
          end
          if (m_bidx < 65535) m_bidx++;
        end
        if (hit && m_tgt != 0 && m_cnt == m_tgt) m_state = 2;
        else if (stop) m_state = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic sbit(bit b, int want = -1);
    in_valid = 1'b1; din = b; dir_out = want; step(); in_valid = 1'b0;
  endtask

  task automatic cfg(logic [MAX_LEN-1:0] p, int l, bit ov, int t);
    cfg_valid = 1'b1; cfg_pattern = p; cfg_len = LEN_W'(l); cfg_overlap = ov;
    cfg_target = CNT_W'(t); step(); cfg_valid = 1'b0;
  endtask

  task automatic go();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic halt();
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  function automatic void chk(string n, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", n, act, exp, $time);
    end
  endfunction

  // Monitor: compare every presented cycle against the queued prediction.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk("out", int'(dout), int'(mon_e.out));
      chk("busy", int'(busy), int'(mon_e.busy));
      chk("done", int'(done), int'(mon_e.done));
      chk("cfg_ready", int'(cfg_ready), int'(mon_e.ready));
      chk("cfg_err", int'(cfg_err), int'(mon_e.err));
      chk("match_cnt", int'(match_cnt), mon_e.cnt);
`ifdef SEQ_DET_FIRST_MATCH_IDX_EN
      chk("first_vld", int'(first_vld), int'(mon_e.fvld));
      chk("first_idx", int'(first_idx), mon_e.fidx);
`endif
      if (mon_e.d_cnt >= 0)  chk("plan_cnt", int'(match_cnt), mon_e.d_cnt);
      if (mon_e.d_busy >= 0) chk("plan_busy", int'(busy), mon_e.d_busy);
      if (mon_e.d_done >= 0) chk("plan_done", int'(done), mon_e.d_done);
      if (mon_e.d_out >= 0)  chk("plan_out", int'(dout), mon_e.d_out);
      if (mon_e.d_err >= 0)  chk("plan_err", int'(cfg_err), mon_e.d_err);
    end
    if (fin_req) begin
      chk("drain", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_overlap = 1'b0; start = 1'b0; stop = 1'b0;
    in_valid = 1'b0; din = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_target = '0;
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    rst = 1'b0;
    dir_cnt = 0; dir_busy = 0; dir_done = 0; dir_err = 0;
    step();

    // Default 1101, overlapping.
    go();
    sbit(1, 0); sbit(1, 0); sbit(0, 0); sbit(1, 1); sbit(1, 0); sbit(0, 0); sbit(1, 1);
    dir_cnt = 2; dir_busy = 1; step();

    // Non-overlapping.
    halt(); cfg(8'h0D, 4, 1'b0, 0); go();
    sbit(1, 0); sbit(1, 0); sbit(0, 0); sbit(1, 1); sbit(1, 0); sbit(0, 0); sbit(1, 0);
    dir_cnt = 1; step();

    // Pattern 101, target 2.
    halt(); cfg(8'h05, 3, 1'b1, 2); go();
    sbit(1, 0); sbit(0, 0); sbit(1, 1); sbit(0, 0); sbit(1, 1);
    dir_done = 1; dir_cnt = 2; step();
    sbit(1, 0); sbit(1, 0); sbit(0, 0); sbit(1, 0);

    // Illegal lengths, then config attempt during a run.
    rst = 1'b1; step(); rst = 1'b0;
    cfg(8'h05, 1, 1'b1, 0);
    dir_err = 1; cfg(8'h05, MAX_LEN + 1, 1'b1, 0);
    dir_err = 1; step();
    go();
    sbit(1, 0); sbit(1, 0); sbit(0, 0); sbit(1, 1);
    cfg(8'h05, 3, 1'b1, 0);
    sbit(1, 0); sbit(0, 0); sbit(1, 1);

    // Gapped bits with toggling data, stop on the matching bit.
    halt(); go();
    sbit(1); din = 1'($urandom); step(); din = ~din; step();
    sbit(1); din = 1'($urandom); step(); din = ~din; step();
    sbit(0); din = 1'b1; step(); din = 1'b0; step();
    stop = 1'b1; sbit(1, 1); stop = 1'b0;
    dir_cnt = 1; dir_busy = 0; step();

    // Reset mid-run clears history.
    go(); sbit(1); sbit(1); sbit(0);
    rst = 1'b1; step(); rst = 1'b0;
    go(); sbit(1, 0);
    dir_cnt = 0; step();

    // Counter saturation with unlimited target.
    halt(); cfg(8'h03, 2, 1'b1, 0); go();
    for (int i = 0; i < 300; i++) sbit(1);
    dir_cnt = 255; step();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 299) == 0);
      cfg_valid   = ($urandom_range(0, 39) == 0);
      cfg_pattern = MAX_LEN'($urandom);
      cfg_len     = LEN_W'($urandom_range(0, 15));
      cfg_overlap = 1'($urandom);
      cfg_target  = CNT_W'($urandom_range(0, 5));
      start       = ($urandom_range(0, 24) == 0);
      stop        = ($urandom_range(0, 59) == 0);
      in_valid    = ($urandom_range(0, 3) != 0);
      din         = 1'($urandom);
      step();
    end
    rst = 1'b0; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0; in_valid = 1'b0;
    fin_req = 1'b1;
  end

endmodule
